square_note_channel: RTL and testbench

- Single square-wave tone channel; consumes the 2-bit top-level sequencer state (00=RESET, 01=LOAD, 10=START, 11=PLAY) and is the receiving end of that sequencing interface.
- Latches a note descriptor in LOAD and triggers in START.
- In PLAY, generates an 8-step duty-cycle square wave at the programmed frequency until its length timer expires.
- Output is a 4-bit amplitude sample for the downstream mixer.
- Runs on the 2^22 Hz system clock.

---
 rtl/square_note_channel_if.sv | 21 ++
 rtl/square_note_channel.sv | 145 ++++++++++++++
 tb/tb_square_note_channel.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/square_note_channel_if.sv
// Sequencer-to-channel link: the sequencer drives state and note descriptor,
// the channel returns its amplitude sample and sounding flag.
interface square_note_channel_if;
  logic [1:0]  state;
  logic [10:0] note_freq;
  logic [5:0]  note_len;
  logic [1:0]  note_duty;
  logic [3:0]  note_vol;
  logic [3:0]  sample;
  logic        active;

  modport master (
    output state, note_freq, note_len, note_duty, note_vol,
    input  sample, active
  );

  modport slave (
    input  state, note_freq, note_len, note_duty, note_vol,
    output sample, active
  );
endinterface

// File: rtl/square_note_channel.sv
// Square-wave tone channel: latches a note in LOAD, arms in START, and in PLAY
// steps through an 8-position duty pattern at the programmed frequency until
// the length timer (in LEN_DIV-cycle ticks) runs out.
module square_note_channel #(
  parameter int LEN_DIV          = 16384,
  parameter int TIMER_MULT_SHIFT = 2
) (
  input logic                  clk,
  input logic                  reset,
  square_note_channel_if.slave bus
);

  localparam int PRE_W = (LEN_DIV > 1) ? $clog2(LEN_DIV) : 1;

  typedef enum logic [1:0] {
    SEQ_RESET = 2'b00,
    SEQ_LOAD  = 2'b01,
    SEQ_START = 2'b10,
    SEQ_PLAY  = 2'b11
  } seqState_e;

  seqState_e seqState;

  logic [10:0]      freq_q, freq_d;
  logic [5:0]       len_q, len_d;
  logic [1:0]       duty_q, duty_d;
  logic [3:0]       vol_q, vol_d;
  logic [13:0]      timer_q, timer_d;
  logic [2:0]       dutyPos_q, dutyPos_d;
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [5:0]       lenCnt_q, lenCnt_d;
  logic             active_q, active_d;
  logic [3:0]       sample_q, sample_d;

  logic [14:0] periodBase;
  logic [13:0] reload;
  logic [7:0]  pattern;

  // Waveform shape per duty code; bit index is the current duty position.
  function automatic logic [7:0] dutyPattern(input logic [1:0] duty);
    case (duty)
      2'b00:   return 8'b1000_0000;
      2'b01:   return 8'b1000_0001;
      2'b10:   return 8'b1110_0001;
      default: return 8'b0111_1110;
    endcase
  endfunction

  assign seqState   = seqState_e'(bus.state);
  // 2048 - freq is at most 2048, so shifting by 2 peaks at 8192 and fits 14 bits.
  assign periodBase = 15'd2048 - {4'd0, freq_q};
  assign reload     = 14'(periodBase << TIMER_MULT_SHIFT);
  assign pattern    = dutyPattern(duty_q);

  // Next-state logic driven by the sequencer state; registers hold by default.
  always_comb begin
    freq_d      = freq_q;
    len_d       = len_q;
    duty_d      = duty_q;
    vol_d       = vol_q;
    timer_d     = timer_q;
    dutyPos_d   = dutyPos_q;
    prescaler_d = prescaler_q;
    lenCnt_d    = lenCnt_q;
    active_d    = active_q;
    sample_d    = (active_q && pattern[dutyPos_q]) ? vol_q : 4'd0;

    case (seqState)
      SEQ_RESET: begin
        active_d    = 1'b0;
        timer_d     = '0;
        dutyPos_d   = '0;
        prescaler_d = '0;
        lenCnt_d    = '0;
      end
      SEQ_LOAD: begin
        freq_d   = bus.note_freq;
        len_d    = bus.note_len;
        duty_d   = bus.note_duty;
        vol_d    = bus.note_vol;
        active_d = 1'b0;
      end
      SEQ_START: begin
        timer_d     = reload;
        dutyPos_d   = '0;
        prescaler_d = '0;
        lenCnt_d    = len_q;
        active_d    = (len_q != 6'd0);
      end
      SEQ_PLAY: begin
        if (active_q) begin
          if (timer_q == 14'd1) begin
            timer_d   = reload;
            dutyPos_d = dutyPos_q + 3'd1;
          end else begin
            timer_d = timer_q - 14'd1;
          end
          if (prescaler_q == PRE_W'(LEN_DIV - 1)) begin
            prescaler_d = '0;
            lenCnt_d    = lenCnt_q - 6'd1;
            if (lenCnt_q == 6'd1) begin
              active_d = 1'b0;
            end
          end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
          end
        end
      end
      default: begin
        active_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that overrides the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_q      <= '0;
      len_q       <= '0;
      duty_q      <= '0;
      vol_q       <= '0;
      timer_q     <= '0;
      dutyPos_q   <= '0;
      prescaler_q <= '0;
      lenCnt_q    <= '0;
      active_q    <= 1'b0;
      sample_q    <= '0;
    end else begin
      freq_q      <= freq_d;
      len_q       <= len_d;
      duty_q      <= duty_d;
      vol_q       <= vol_d;
      timer_q     <= timer_d;
      dutyPos_q   <= dutyPos_d;
      prescaler_q <= prescaler_d;
      lenCnt_q    <= lenCnt_d;
      active_q    <= active_d;
      sample_q    <= sample_d;
    end
  end

  assign bus.sample = sample_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_square_note_channel.sv
// Self-checking bench for square_note_channel: a stimulus process drives the
// sequencer side and queues the expected sample/active per clock from a
// behavioural note model; a monitor pops and compares on the falling edge.
module tb_square_note_channel;

  localparam int LEN_DIV = 256;
  localparam int SHIFT   = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  square_note_channel_if bus ();

  square_note_channel #(
    .LEN_DIV         (LEN_DIV),
    .TIMER_MULT_SHIFT(SHIFT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0] sample;
    logic       active;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural note model: latched descriptor plus the number of PLAY cycles
  // spent sounding since the last START.
  int mFreq  = 0;
  int mLen   = 0;
  int mDuty  = 0;
  int mVol   = 0;
  bit mArmed = 1'b0;
  int mK     = 0;

  function automatic bit modelActive();
    return mArmed && (mK < mLen * LEN_DIV);
  endfunction

  function automatic int modelPos();
    int period;
    period = (2048 - mFreq) * (1 << SHIFT);
    return (mK / period) % 8;
  endfunction

  function automatic bit patternBit(input int duty, input int pos);
    bit [7:0] pats[4];
    pats[0] = 8'b1000_0000;
    pats[1] = 8'b1000_0001;
    pats[2] = 8'b1110_0001;
    pats[3] = 8'b0111_1110;
    return pats[duty][pos];
  endfunction

  // Drive one clock of sequencer inputs, advance the model by that edge and
  // queue the response the channel should show afterwards.
  task automatic applyStimulus(input bit rst, input logic [1:0] st,
                               input logic [10:0] f, input logic [5:0] l,
                               input logic [1:0] d, input logic [3:0] v,
                               input string tag);
    bit   prevActive;
    int   prevPos;
    exp_t e;
    reset         = rst;
    bus.state     = st;
    bus.note_freq = f;
    bus.note_len  = l;
    bus.note_duty = d;
    bus.note_vol  = v;
    @(posedge clk);
    prevActive = modelActive();
    prevPos    = modelPos();
    e.sample   = (prevActive && patternBit(mDuty, prevPos)) ? 4'(mVol) : 4'd0;
    if (rst) begin
      e.sample = 4'd0;
      mFreq = 0; mLen = 0; mDuty = 0; mVol = 0;
      mArmed = 1'b0; mK = 0;
    end else begin
      case (st)
        2'b00: mArmed = 1'b0;
        2'b01: begin
          mFreq = int'(f); mLen = int'(l); mDuty = int'(d); mVol = int'(v);
          mArmed = 1'b0;
        end
        2'b10: begin
          mArmed = 1'b1;
          mK     = 0;
        end
        default: if (modelActive()) mK++;
      endcase
    end
    e.active = modelActive();
    e.tag    = tag;
    expQ.push_back(e);
    #1;
  endtask

  // One clock in the given state with random, irrelevant note inputs.
  task automatic randStep(input logic [1:0] st, input string tag);
    applyStimulus(1'b0, st, 11'($urandom), 6'($urandom), 2'($urandom),
                  4'($urandom), tag);
  endtask

  task automatic playNote(input int f, input int l, input int d, input int v,
                          input int playCycles, input string tag);
    applyStimulus(1'b0, 2'b01, 11'(f), 6'(l), 2'(d), 4'(v), tag);
    randStep(2'b10, tag);
    for (int i = 0; i < playCycles; i++) randStep(2'b11, tag);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (bus.sample !== e.sample || bus.active !== e.active) begin
        failures++;
        $display("[TB] FAIL %s: got sample=%0d active=%0b, expected sample=%0d active=%0b at %0t",
                 e.tag, bus.sample, bus.active, e.sample, e.active, $time);
      end
    end
  endtask

  // Monitor: the channel presents a sample every clock; compare it mid-cycle.
  always @(negedge clk) checkOutput();

  initial begin
    int f, l, d, v, n;
    reset         = 1'b1;
    bus.state     = 2'b00;
    bus.note_freq = '0;
    bus.note_len  = '0;
    bus.note_duty = '0;
    bus.note_vol  = '0;

    $display("[TB] reset with sequencer activity");
    applyStimulus(1'b1, 2'b01, 11'd2047, 6'd5, 2'd2, 4'd15, "reset_load");
    applyStimulus(1'b1, 2'b10, 11'd2047, 6'd5, 2'd2, 4'd15, "reset_start");
    applyStimulus(1'b1, 2'b11, 11'd2047, 6'd5, 2'd2, 4'd15, "reset_play");

    $display("[TB] fastest note, one length tick, 50 percent");
    playNote(2047, 1, 2, 15, LEN_DIV + 10, "fast_len1");

    $display("[TB] zero length never sounds");
    playNote(1000, 0, 3, 15, 100, "len0");

    $display("[TB] zero volume sounds silently");
    playNote(2040, 2, 3, 0, 2 * LEN_DIV + 4, "vol0");

    $display("[TB] slowest note truncated by LOAD");
    playNote(0, 63, 0, 9, 3000, "slow_trunc");

    $display("[TB] full length note");
    playNote(1900, 63, 3, 11, 63 * LEN_DIV + 20, "len63");

    $display("[TB] RESET state mid note then PLAY stays silent");
    playNote(2030, 3, 1, 6, 200, "hold_pre");
    for (int i = 0; i < 3; i++) randStep(2'b00, "hold_rst");
    for (int i = 0; i < 20; i++) randStep(2'b11, "hold_play");
    randStep(2'b10, "restart");
    for (int i = 0; i < 3 * LEN_DIV + 5; i++) randStep(2'b11, "restart");

    $display("[TB] reset mid PLAY then normal note");
    playNote(2040, 63, 2, 12, 500, "midreset");
    applyStimulus(1'b1, 2'b11, 11'd5, 6'd5, 2'd1, 4'd3, "midreset_rst");
    playNote(2047, 2, 1, 7, 2 * LEN_DIV + 5, "after_reset");

    $display("[TB] random notes");
    for (int i = 0; i < 12; i++) begin
      f = 1900 + $urandom_range(0, 147);
      l = $urandom_range(0, 6);
      d = $urandom_range(0, 3);
      v = $urandom_range(0, 15);
      n = l * LEN_DIV + $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(1, l * LEN_DIV + 1);
      playNote(f, l, d, v, n, "rand_note");
    end

    $display("[TB] random state sequencing");
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0)
        applyStimulus(1'b0, 2'b01, 11'(2040 + $urandom_range(0, 7)),
                      6'($urandom_range(0, 2)), 2'($urandom), 4'($urandom),
                      "rand_state");
      else if (n == 1) randStep(2'b10, "rand_state");
      else if (n == 2) randStep(2'b00, "rand_state");
      else randStep(2'b11, "rand_state");
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
